// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver, LSB first. Samples each bit at mid-bit, rejects start-bit glitches,
// and drops frames whose stop bit is low so only clean bytes reach the packet receiver.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 868,
    localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_interrupt,
    output logic [7:0] rx_data,
    output logic       frame_error,
    output logic       rx_busy
);

    // state | meaning
    // IDLE  | line idle, waiting for a falling edge on rx_s
    // START | timing to the middle of the start bit to confirm it
    // DATA  | sampling the eight data bits at mid-bit
    // STOP  | sampling the stop bit; forward the byte or flag a framing error
    // BREAK | stop bit was low; wait for the line to return high
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic [7:0]       rx_data_q;
    logic             rx_int_q;
    logic             frame_err_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_int_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_int_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        shreg_q   <= {rx_s_q, shreg_q[7:1]};
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            rx_data_q <= shreg_q;
                            rx_int_q  <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // A held-low line must not decode as a stream of 0x00 bytes.
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_interrupt = rx_int_q;
    assign rx_data      = rx_data_q;
    assign frame_error  = frame_err_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 16 clk/bit: normal, back-to-back, glitch,
// framing error, mid-frame reset and bit-period tolerance.
module tb_uart_byte_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_interrupt;
    logic [7:0] rx_data;
    logic       frame_error;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_interrupt (rx_interrupt),
        .rx_data      (rx_data),
        .frame_error  (frame_error),
        .rx_busy      (rx_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         int_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    int         busy_after_strobe = 0;
    logic       prev_int = 1'b0;
    logic       prev_fe = 1'b0;
    logic       chk_busy = 1'b0;
    logic [7:0] got_q[$];
    int         cyc_q[$];

    always @(negedge clk) begin
        if (rx_interrupt === 1'b1) begin
            int_cnt++;
            got_q.push_back(rx_data);
            cyc_q.push_back(cyc);
        end
        if (frame_error === 1'b1) fe_cnt++;
        if (rx_interrupt === 1'b1 && frame_error === 1'b1) both_cnt++;
        if ((rx_interrupt === 1'b1 && prev_int) || (frame_error === 1'b1 && prev_fe)) wide_cnt++;
        if (chk_busy && rx_busy !== 1'b0) busy_after_strobe++;
        chk_busy = (rx_interrupt === 1'b1);
        prev_int = (rx_interrupt === 1'b1);
        prev_fe  = (frame_error === 1'b1);
    end

    function automatic logic [7:0] pop_byte();
        if (got_q.size() == 0) return 8'hxx;
        return got_q.pop_front();
    endfunction

    function automatic int pop_cyc();
        if (cyc_q.size() == 0) return -1;
        return cyc_q.pop_front();
    endfunction

    // Called and returns at posedge+1 so every drive lands between clock edges.
    task automatic drive_bit(input logic b, input int len);
        rx = b;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int len);
        drive_bit(1'b1, len);
    endtask

    // Even-numbered bits (start, d1, d3, ...) last p_even clocks, odd ones p_odd.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int p_even, input int p_odd);
        logic b;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i == 9) b = stop_v;
            else             b = d[i-1];
            drive_bit(b, (i % 2 == 0) ? p_even : p_odd);
        end
    endtask

    int c0, i0, f0, t1, t2;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_int", rx_interrupt, 1'b0);
        check("reset_data", rx_data, 8'h00);
        check("reset_fe", frame_error, 1'b0);
        check("reset_busy", rx_busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(10);

        // Single byte: strobe 155 clk after the start edge is driven.
        c0 = cyc;
        i0 = int_cnt;
        send_frame(8'hA4, 1'b1, CPB, CPB);
        idle(20);
        check("a4_count", int_cnt - i0, 1);
        check("a4_data", pop_byte(), 8'hA4);
        check("a4_latency", pop_cyc() - c0, 155);
        check("a4_no_fe", fe_cnt, 0);
        check("a4_idle_busy", rx_busy, 1'b0);

        // Back-to-back frames, no idle gap.
        i0 = int_cnt;
        send_frame(8'h82, 1'b1, CPB, CPB);
        send_frame(8'h00, 1'b1, CPB, CPB);
        idle(20);
        check("b2b_count", int_cnt - i0, 2);
        check("b2b_data0", pop_byte(), 8'h82);
        check("b2b_data1", pop_byte(), 8'h00);
        t1 = pop_cyc();
        t2 = pop_cyc();
        check("b2b_spacing", t2 - t1, 160);

        // Start-bit glitch of 4 clk.
        i0 = int_cnt;
        f0 = fe_cnt;
        drive_bit(1'b0, 4);
        idle(30);
        check("glitch_no_int", int_cnt - i0, 0);
        check("glitch_no_fe", fe_cnt - f0, 0);
        check("glitch_busy", rx_busy, 1'b0);
        send_frame(8'h5A, 1'b1, CPB, CPB);
        idle(20);
        check("glitch_next_count", int_cnt - i0, 1);
        check("glitch_next_data", pop_byte(), 8'h5A);

        // Framing error with the line held low afterwards.
        i0 = int_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, CPB, CPB);
        drive_bit(1'b0, 40);
        check("break_busy", rx_busy, 1'b1);
        idle(30);
        check("fe_count", fe_cnt - f0, 1);
        check("fe_no_int", int_cnt - i0, 0);
        check("fe_data_kept", rx_data, 8'h5A);
        check("fe_busy_released", rx_busy, 1'b0);
        send_frame(8'hFF, 1'b1, CPB, CPB);
        idle(20);
        check("fe_next_count", int_cnt - i0, 1);
        check("fe_next_data", pop_byte(), 8'hFF);

        // Reset during data bit 4 of 0xC3.
        i0 = int_cnt;
        f0 = fe_cnt;
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b0, 8);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mid_data", rx_data, 8'h00);
        check("rst_mid_busy", rx_busy, 1'b0);
        check("rst_mid_int", rx_interrupt, 1'b0);
        check("rst_mid_fe", frame_error, 1'b0);
        idle(200);
        check("rst_mid_no_int", int_cnt - i0, 0);
        check("rst_mid_no_fe", fe_cnt - f0, 0);
        send_frame(8'h11, 1'b1, CPB, CPB);
        idle(20);
        check("rst_next_data", pop_byte(), 8'h11);

        // Bit-period tolerance. Sampling lands 8+16*k clk after the start edge, so a
        // uniform 15 or 17 clk bit drifts out of bit 7 / the stop bit; use 15.5 and 16.5 averages.
        f0 = fe_cnt;
        i0 = int_cnt;
        send_frame(8'h55, 1'b1, 16, 17);
        idle(20);
        check("slow_data", pop_byte(), 8'h55);
        send_frame(8'h55, 1'b1, 16, 15);
        idle(20);
        check("fast_data", pop_byte(), 8'h55);
        check("tol_count", int_cnt - i0, 2);
        check("tol_no_fe", fe_cnt - f0, 0);

        check("strobes_exclusive", both_cnt, 0);
        check("strobes_one_cycle", wide_cnt, 0);
        check("busy_low_after_strobe", busy_after_strobe, 0);
        check("no_stray_bytes", got_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
